// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for the transmitter arbiter: FSM encoding and default sizing.
package tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    LAUNCH   = 2'b01,
    WAIT_ACK = 2'b10,
    COOLDOWN = 2'b11
  } arb_state_t;

  localparam int DEF_N_CLIENTS      = 4;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_IDX_W          = 2;
  localparam int DEF_COOL_CYCLES    = 4;
  localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, with wrap.
module rr_pick #(
  parameter int N_CLIENTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [N_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     grant,
  output logic                 any_valid
);

  int                   cand;
  logic [N_CLIENTS-1:0] cand_mask;

  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    cand      = 0;
    cand_mask = '0;
    for (int i = 1; i <= N_CLIENTS; i++) begin
      cand      = (int'(ptr) + i) % N_CLIENTS;
      cand_mask = N_CLIENTS'(1) << cand;
      if (!any_valid && ((req & cand_mask) != '0)) begin
        grant     = IDX_W'(cand);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one 4-phase push-synchronizer transmitter between N clients.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int N_CLIENTS      = DEF_N_CLIENTS,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int IDX_W          = DEF_IDX_W,
  parameter int COOL_CYCLES    = DEF_COOL_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [N_CLIENTS-1:0]            cli_valid,
  input  logic [N_CLIENTS*DATA_WIDTH-1:0] cli_data,
  output logic [N_CLIENTS-1:0]            cli_ready,
  output logic [N_CLIENTS-1:0]            cli_done,
  output logic                            tx_v,
  output logic [DATA_WIDTH-1:0]           tx_data,
  input  logic                            tx_req,
  input  logic                            tx_f,
  output logic                            busy,
  output logic [IDX_W-1:0]                grant_idx,
  output logic                            timeout_err,
  input  logic                            clr_err
);

  // One counter serves both the ack timeout and the post-ack cooldown.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > COOL_CYCLES) ? TIMEOUT_CYCLES : COOL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  arb_state_t            state, next_state;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [IDX_W-1:0]      ptr, ptr_d;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_valid;
  logic                  expire;
  logic                  tx_v_d, busy_d, timeout_d;
  logic [N_CLIENTS-1:0]  cli_ready_d, cli_done_d;
  logic [DATA_WIDTH-1:0] tx_data_d;
  logic [IDX_W-1:0]      grant_d;

  rr_pick #(
    .N_CLIENTS (N_CLIENTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req       (cli_valid),
    .ptr       (ptr),
    .grant     (pick_idx),
    .any_valid (pick_valid)
  );

  // A late ack landing in the expiry cycle still counts as a normal completion.
  assign expire = (state == WAIT_ACK) && !tx_f && ((cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      ptr         <= IDX_W'(N_CLIENTS - 1);
      tx_v        <= 1'b0;
      cli_ready   <= '0;
      cli_done    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      tx_data     <= '0;
      grant_idx   <= '0;
    end else begin
      state       <= next_state;
      cnt         <= cnt_next;
      ptr         <= ptr_d;
      tx_v        <= tx_v_d;
      cli_ready   <= cli_ready_d;
      cli_done    <= cli_done_d;
      busy        <= busy_d;
      timeout_err <= timeout_d;
      tx_data     <= tx_data_d;
      grant_idx   <= grant_d;
    end
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (pick_valid) next_state = LAUNCH;
      end
      LAUNCH: begin
        next_state = WAIT_ACK;
        cnt_next   = '0;
      end
      WAIT_ACK: begin
        if (tx_f || expire) begin
          next_state = COOLDOWN;
          cnt_next   = CNT_W'(COOL_CYCLES);
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      COOLDOWN: begin
        if (cnt != '0) cnt_next = cnt - CNT_W'(1);
        else if (!tx_req) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are computed one cycle early so every port comes straight from a flop.
  always_comb begin
    tx_v_d      = 1'b0;
    cli_ready_d = '0;
    cli_done_d  = '0;
    tx_data_d   = tx_data;
    grant_d     = grant_idx;
    ptr_d       = ptr;
    busy_d      = (next_state != IDLE);
    timeout_d   = timeout_err;
    if (clr_err) timeout_d = 1'b0;
    if (expire)  timeout_d = 1'b1;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          tx_v_d      = 1'b1;
          cli_ready_d = N_CLIENTS'(1) << pick_idx;
          tx_data_d   = cli_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
          grant_d     = pick_idx;
        end
      end
      WAIT_ACK: begin
        if (tx_f) cli_done_d = N_CLIENTS'(1) << grant_idx;
      end
      COOLDOWN: begin
        if (next_state == IDLE) ptr_d = grant_idx;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed self-checking bench for tx_arbiter: vector table plus multi-cycle corner sequences.
module tb_tx_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  cli_valid;
  logic [31:0] cli_data;
  logic [3:0]  cli_ready;
  logic [3:0]  cli_done;
  logic        tx_v;
  logic [7:0]  tx_data;
  logic        tx_req;
  logic        tx_f;
  logic        busy;
  logic [1:0]  grant_idx;
  logic        timeout_err;
  logic        clr_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          ack;
    logic [1:0]  exp_idx;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[11];

  tx_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cli_valid   (cli_valid),
    .cli_data    (cli_data),
    .cli_ready   (cli_ready),
    .cli_done    (cli_done),
    .tx_v        (tx_v),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .tx_f        (tx_f),
    .busy        (busy),
    .grant_idx   (grant_idx),
    .timeout_err (timeout_err),
    .clr_err     (clr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  // Present a request from IDLE, check the launch cycle, then step into WAIT_ACK.
  task automatic launchWord(input logic [3:0] valid, input logic [31:0] data,
                            input logic [1:0] exp_idx, input logic [7:0] exp_data);
    logic [3:0] oh;
    oh = 4'b0001 << exp_idx;
    cli_valid = valid;
    cli_data  = data;
    tick();
    checkOutput("launch tx_v", 32'(tx_v), 32'd1);
    checkOutput("launch cli_ready", 32'(cli_ready), 32'(oh));
    checkOutput("launch tx_data", 32'(tx_data), 32'(exp_data));
    checkOutput("launch grant_idx", 32'(grant_idx), 32'(exp_idx));
    checkOutput("launch busy", 32'(busy), 32'd1);
    cli_valid = 4'b0000;
    tick();
    checkOutput("wait tx_v low", 32'(tx_v), 32'd0);
    checkOutput("wait cli_ready low", 32'(cli_ready), 32'd0);
    checkOutput("wait tx_data held", 32'(tx_data), 32'(exp_data));
  endtask

  // Full transaction: launch, ack after 'ack' WAIT_ACK cycles, then 5 cooldown cycles.
  task automatic applyStimulus(input vec_t v);
    logic [3:0] oh;
    oh = 4'b0001 << v.exp_idx;
    launchWord(v.valid, v.data, v.exp_idx, v.exp_data);
    repeat (v.ack - 1) tick();
    tx_f = 1'b1;
    tick();
    tx_f = 1'b0;
    checkOutput("ack cli_done", 32'(cli_done), 32'(oh));
    checkOutput("ack no error", 32'(timeout_err), 32'd0);
    tick();
    checkOutput("cli_done single pulse", 32'(cli_done), 32'd0);
    repeat (3) tick();
    checkOutput("cooldown busy", 32'(busy), 32'd1);
    checkOutput("cooldown tx_data held", 32'(tx_data), 32'(v.exp_data));
    tick();
    checkOutput("back to idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic       saw_done;
    logic [3:0] all_valid;

    vecs[0]  = '{4'b1111, 32'h13121110, 6, 2'd0, 8'h10};
    vecs[1]  = '{4'b1111, 32'h13121110, 6, 2'd1, 8'h11};
    vecs[2]  = '{4'b1111, 32'h13121110, 6, 2'd2, 8'h12};
    vecs[3]  = '{4'b1111, 32'h13121110, 6, 2'd3, 8'h13};
    vecs[4]  = '{4'b1111, 32'h13121110, 6, 2'd0, 8'h10};
    vecs[5]  = '{4'b0100, 32'h00A50000, 1, 2'd2, 8'hA5};
    vecs[6]  = '{4'b0011, 32'h0000BBAA, 3, 2'd0, 8'hAA};
    vecs[7]  = '{4'b0011, 32'h0000BBAA, 2, 2'd1, 8'hBB};
    vecs[8]  = '{4'b1001, 32'hDD0000CC, 6, 2'd3, 8'hDD};
    vecs[9]  = '{4'b1001, 32'hDD0000CC, 1, 2'd0, 8'hCC};
    vecs[10] = '{4'b1000, 32'h7E000000, 4, 2'd3, 8'h7E};

    reset_n   = 1'b0;
    cli_valid = 4'b0000;
    cli_data  = 32'h0;
    tx_req    = 1'b0;
    tx_f      = 1'b0;
    clr_err   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("reset tx_v", 32'(tx_v), 32'd0);
    checkOutput("reset cli_ready", 32'(cli_ready), 32'd0);
    checkOutput("reset cli_done", 32'(cli_done), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("reset tx_data", 32'(tx_data), 32'd0);
    checkOutput("reset grant_idx", 32'(grant_idx), 32'd0);
    reset_n = 1'b1;

    $display("[TB] round-robin vector table");
    for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

    $display("[TB] ack timeout, clear collides with expiry");
    launchWord(4'b0001, 32'h000000EE, 2'd0, 8'hEE);
    saw_done = 1'b0;
    for (int i = 0; i < 254; i++) begin
      tick();
      saw_done = saw_done | (cli_done != 4'b0000);
    end
    checkOutput("pre-expiry no error", 32'(timeout_err), 32'd0);
    checkOutput("pre-expiry busy", 32'(busy), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("expiry sets error over clear", 32'(timeout_err), 32'd1);
    checkOutput("expiry no cli_done", 32'(cli_done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      saw_done = saw_done | (cli_done != 4'b0000);
    end
    checkOutput("timeout never done", 32'(saw_done), 32'd0);
    checkOutput("timeout cooldown busy", 32'(busy), 32'd1);
    tick();
    checkOutput("timeout back to idle", 32'(busy), 32'd0);
    checkOutput("timeout error sticky", 32'(timeout_err), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("clr_err clears", 32'(timeout_err), 32'd0);

    $display("[TB] ack in the expiry cycle");
    launchWord(4'b0010, 32'h0000DD00, 2'd1, 8'hDD);
    repeat (254) tick();
    tx_f = 1'b1;
    tick();
    tx_f = 1'b0;
    checkOutput("late ack cli_done", 32'(cli_done), 32'b0010);
    checkOutput("late ack no error", 32'(timeout_err), 32'd0);
    repeat (5) tick();
    checkOutput("late ack back to idle", 32'(busy), 32'd0);
    checkOutput("late ack still no error", 32'(timeout_err), 32'd0);

    $display("[TB] tx_req held through cooldown");
    launchWord(4'b0100, 32'h00C30000, 2'd2, 8'hC3);
    tx_req = 1'b1;
    tx_f   = 1'b1;
    tick();
    tx_f = 1'b0;
    checkOutput("req hold cli_done", 32'(cli_done), 32'b0100);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("req hold busy", 32'(busy), 32'd1);
    end
    tx_req = 1'b0;
    tick();
    checkOutput("req released idle", 32'(busy), 32'd0);

    $display("[TB] asynchronous reset mid-handshake");
    all_valid = 4'b1111;
    launchWord(all_valid, 32'h44332211, 2'd3, 8'h44);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset tx_data", 32'(tx_data), 32'd0);
    checkOutput("async reset grant_idx", 32'(grant_idx), 32'd0);
    checkOutput("async reset tx_v", 32'(tx_v), 32'd0);
    checkOutput("async reset cli_done", 32'(cli_done), 32'd0);
    #2;
    reset_n = 1'b1;
    tick();
    checkOutput("post reset idle", 32'(busy), 32'd0);
    applyStimulus('{all_valid, 32'h44332211, 2, 2'd0, 8'h11});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
